// File: rtl/md_seq.sv
// md_seq: multiply/divide sequencer that owns the HI/LO register pair.
// Results are computed when an op is accepted and released to HI/LO after a fixed latency.
//
// state | meaning
// IDLE  | ready; MD ops accepted, MTHI/MTLO write HI/LO directly
// MUL   | multiply in flight, cnt counts down from MULT_LAT-1
// DIV   | divide in flight, cnt counts down from DIV_LAT-1
module md_seq #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        kill,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_dz;

  logic        accept;
  logic        is_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign accept    = start & ~kill & (state == ST_IDLE);
  // op[0] clear selects the signed variant for both MULT and DIV
  assign is_signed = ~op[0];

  // Sign- or zero-extend to 64 bits so one unsigned multiplier serves both forms
  assign a_ext = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
  assign b_ext = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes; 0x80000000 stays 0x80000000 as a magnitude, giving the wrap case for free
  assign a_neg = is_signed & a[31];
  assign b_neg = is_signed & b[31];
  assign a_mag = a_neg ? (32'd0 - a) : a;
  assign b_mag = b_neg ? (32'd0 - b) : b;
  assign div_b = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / div_b;
  assign r_mag = a_mag % div_b;
  assign quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  assign busy = reset & ((state != ST_IDLE) | (start & ~kill & (op <= OP_DIVU)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_dz <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                res_hi <= prod[63:32];
                res_lo <= prod[31:0];
                res_dz <= 1'b0;
                cnt    <= MULT_CNT;
                state  <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                res_hi <= rem;
                res_lo <= quo;
                res_dz <= (b == 32'd0);
                cnt    <= DIV_CNT;
                state  <= ST_DIV;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // A divide by zero burns its full latency but leaves HI/LO untouched
            if (!res_dz) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 Parameter MULT_LAT, default 5: busy cycles for MULT/MULTU, legal range 1..15.
REQ-002 Parameter DIV_LAT, default 10: busy cycles for DIV/DIVU, legal range 1..15.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-low.
REQ-005 Port start  input  1  E-stage MD instruction valid this cycle.
REQ-006 Port op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=reserved.
REQ-007 Port kill  input  1  E-stage instruction cancelled by exception/eret flush this cycle.
REQ-008 Port a  input  32  rs operand, already forwarded.
REQ-009 Port b  input  32  rt operand, already forwarded.
REQ-010 Port busy  output  1  start-cycle or in-flight operation; feeds hazard-unit BUSY for MF/MT stall.
REQ-011 Port hi  output  32  HI register.
REQ-012 Port lo  output  32  LO register.

Function
REQ-013 States: IDLE, MUL, DIV; 4-bit down-counter cnt.
REQ-014 Accept = start & ~kill & state==IDLE; any other start is ignored with no state change.
REQ-015 Accept with op 0/1: latch a*b (signed for 0, unsigned for 1), 64-bit product; go to MUL; cnt loads MULT_LAT-1.
REQ-016 Accept with op 2/3: latch quotient and remainder (signed for 2, unsigned for 3); go to DIV; cnt loads DIV_LAT-1.
REQ-017 Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend; 0x80000000/-1 gives quotient 0x80000000, remainder 0.
REQ-018 Divide by zero still runs the full DIV_LAT cycles, then leaves hi/lo unchanged.
REQ-019 In MUL/DIV: each edge with cnt!=0 decrements cnt.
REQ-020 In MUL/DIV: the edge with cnt==0 writes the result (hi=product[63:32] or remainder; lo=product[31:0] or quotient) and returns to IDLE.
REQ-021 Op 4 accepted: hi<=a on that edge. Op 5 accepted: lo<=a on that edge. No state change, busy not extended.
REQ-022 Ops 6/7 accepted: no effect.
REQ-023 busy = (state!=IDLE) | (start & ~kill & op<=3), combinational.
REQ-024 Mult op: busy is high from the start cycle through MULT_LAT further cycles. Div op: same with DIV_LAT.
REQ-025 hi/lo change only on result write, MTHI/MTLO, or reset; they are stable while busy.
REQ-026 A result is visible on hi/lo in the cycle after the final busy cycle.
REQ-027 A new start may be accepted in the first cycle state==IDLE; back-to-back ops are allowed.
REQ-028 kill while state is MUL/DIV has no effect: an in-flight op completes, since it belongs to an older committed instruction.
REQ-029 Operands are sampled only on the accept edge; later changes to a/b do not alter the result.

Reset
REQ-030 reset==0 at a rising edge: state=IDLE, cnt=0, hi=0, lo=0, latched result=0.
REQ-031 Reset mid-operation aborts the op with no result write.
REQ-032 Reset has priority over start.
REQ-033 busy=0 during and after reset until the next accept.

Verification
REQ-034 MULT a=0xFFFFFFFE(-2), b=3 -> busy high 6 cycles (start + 5); then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 DIVU a=100, b=7 -> busy high 11 cycles; then lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 hi=lo=5, then DIV a=9, b=0 -> busy 11 cycles; hi=lo=5 afterwards.
REQ-037 start with kill=1, op=MULT -> busy=0 that cycle, no state change, hi/lo unchanged.
REQ-038 MULTU 0xFFFFFFFF*0xFFFFFFFF accepted; start (MTLO) asserted on cycle 3 -> ignored; result hi=0xFFFFFFFE, lo=1.
REQ-039 MTHI a=0x1234 -> hi=0x1234 next cycle, busy low. DIV in flight, reset low at cycle 4 -> state IDLE, hi=lo=0, busy=0.
